spi_mstr_gen: RTL and testbench

Parametrised SPI master, the next generation of the team's fixed 16-bit / mode-3 / single-slave master. It supports a configurable transaction width, SCLK rate and porch lengths, all four SPI modes selected per transaction, and multiple slave selects. It sits between the command sequencers and off-chip SPI peripherals (IMU, A2D), one instance per bus.

---
 rtl/spi_mstr_gen.sv | 207 ++++++++++++++++++++
 tb/tb_spi_mstr_gen.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mstr_gen.sv
// -----------------------------------------------------------------------------
// spi_mstr_gen -- parametrised SPI master.
//
// Shifts one WIDTH-bit word out on MOSI (MSB first) while shifting one word in
// from MISO. SPI mode (cpol/cpha) and slave index are latched per transaction,
// so back-to-back transfers may use different modes and slaves.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   wrt      in   start request, taken only while busy=0
//   cmd      in   word to transmit
//   ss_sel   in   slave index; values >= NUM_SS select no slave
//   cpol     in   SCLK idle level
//   cpha     in   0: sample on leading edge, 1: sample on trailing edge
//   MISO     in   serial data from slave
//   busy     out  transaction in progress
//   done     out  one-cycle pulse at end of transaction
//   rd_data  out  last completed received word
//   SCLK     out  serial clock (registered)
//   SS_n     out  active-low slave selects (registered)
//   MOSI     out  serial data to slave (registered)
// -----------------------------------------------------------------------------
module spi_mstr_gen #(
   parameter  int WIDTH    = 16,
   parameter  int NUM_SS   = 4,
   parameter  int HALF_PER = 32,
   parameter  int FRONT    = 2,
   parameter  int BACK     = 16,
   localparam int SSW      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrt,
   input  logic [WIDTH-1:0]  cmd,
   input  logic [SSW-1:0]    ss_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              MISO,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  rd_data,
   output logic              SCLK,
   output logic [NUM_SS-1:0] SS_n,
   output logic              MOSI
);

   // One down-counter serves all timed phases, so size it for the longest.
   localparam int MAXC = (FRONT > HALF_PER) ? ((FRONT > BACK) ? FRONT : BACK)
                                            : ((HALF_PER > BACK) ? HALF_PER : BACK);
   localparam int CW   = $clog2(MAXC);
   localparam int BW   = $clog2(WIDTH);

   localparam logic [CW-1:0] C_FRONT = CW'(FRONT - 1);
   localparam logic [CW-1:0] C_HALF  = CW'(HALF_PER - 1);
   localparam logic [CW-1:0] C_BACK  = CW'(BACK - 1);
   localparam logic [BW-1:0] C_LAST  = BW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, FRONT_P, PH_A, PH_B, BACK_P} state_t;

   state_t            r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt, w_cnt_ld_val;
   logic              w_cnt_ld, w_cnt_zero;
   logic [BW-1:0]     r_bit;
   logic              w_last_bit;
   logic              w_accept, w_lead, w_trail, w_finish;

   logic [WIDTH-1:0]  r_tx, r_rx, r_rd_data;
   logic              r_cpol, r_cpha;
   logic              r_sclk, r_mosi, r_done;
   logic [NUM_SS-1:0] r_ss_n, w_ss_dec;

   assign w_cnt_zero = (r_cnt == '0);
   assign w_last_bit = (r_bit == C_LAST);

   // Out-of-range indices match no line, so the transfer runs unselected.
   always_comb begin
      w_ss_dec = '1;
      for (int i = 0; i < NUM_SS; i++)
         if (ss_sel == SSW'(i)) w_ss_dec[i] = 1'b0;
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // w_lead / w_trail mark the clk edges on which SCLK toggles.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_ld     = 1'b0;
      w_cnt_ld_val = '0;
      w_accept     = 1'b0;
      w_lead       = 1'b0;
      w_trail      = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         IDLE: if (wrt) begin
            w_accept     = 1'b1;
            w_state_nxt  = FRONT_P;
            w_cnt_ld     = 1'b1;
            w_cnt_ld_val = C_FRONT;
         end
         FRONT_P: if (w_cnt_zero) begin
            w_state_nxt  = PH_A;
            w_cnt_ld     = 1'b1;
            w_cnt_ld_val = C_HALF;
         end
         PH_A: if (w_cnt_zero) begin
            w_lead       = 1'b1;
            w_state_nxt  = PH_B;
            w_cnt_ld     = 1'b1;
            w_cnt_ld_val = C_HALF;
         end
         PH_B: if (w_cnt_zero) begin
            w_trail  = 1'b1;
            w_cnt_ld = 1'b1;
            if (w_last_bit) begin
               w_state_nxt  = BACK_P;
               w_cnt_ld_val = C_BACK;
            end else begin
               w_state_nxt  = PH_A;
               w_cnt_ld_val = C_HALF;
            end
         end
         BACK_P: if (w_cnt_zero) begin
            w_finish    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Loaded with (length-1) on phase entry; the phase ends on the cycle it reads 0.
   always_ff @(posedge clk) begin
      if (rst)                  r_cnt <= '0;
      else if (w_cnt_ld)        r_cnt <= w_cnt_ld_val;
      else if (!w_cnt_zero)     r_cnt <= r_cnt - 1'b1;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx      <= '0;
         r_rx      <= '0;
         r_rd_data <= '0;
         r_bit     <= '0;
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
         r_done    <= 1'b0;
         r_ss_n    <= '1;
      end else begin
         r_done <= w_finish;

         // Track the requested idle level so SCLK is already right at start.
         if (r_state == IDLE) r_sclk <= cpol;

         if (w_accept) begin
            r_tx   <= cmd;
            r_rx   <= '0;
            r_mosi <= cmd[WIDTH-1];
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_ss_n <= w_ss_dec;
            r_bit  <= '0;
         end

         if (w_lead) begin
            r_sclk <= ~r_cpol;
            if (!r_cpha) begin
               r_rx <= {r_rx[WIDTH-2:0], MISO};
            end else if (r_bit != '0) begin
               // cpha=1: bit 0 was already presented at acceptance.
               r_tx   <= r_tx << 1;
               r_mosi <= r_tx[WIDTH-2];
            end
         end

         if (w_trail) begin
            r_sclk <= r_cpol;
            r_bit  <= w_last_bit ? '0 : r_bit + 1'b1;
            if (r_cpha) begin
               r_rx <= {r_rx[WIDTH-2:0], MISO};
            end else if (!w_last_bit) begin
               r_tx   <= r_tx << 1;
               r_mosi <= r_tx[WIDTH-2];
            end
         end

         if (w_finish) begin
            r_ss_n    <= '1;
            r_rd_data <= r_rx;
         end
      end
   end

   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign rd_data = r_rd_data;
   assign SCLK    = r_sclk;
   assign SS_n    = r_ss_n;
   assign MOSI    = r_mosi;

endmodule

// File: tb/tb_spi_mstr_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_mstr_gen -- self-checking bench for spi_mstr_gen.
//
// u0: 16-bit, 4 slaves, HALF_PER=4, FRONT=2, BACK=4, driven by a behavioural
//     SPI slave and checked every cycle against a timing model.
// u1: 8-bit, 5 slaves, HALF_PER=2, FRONT=3, BACK=2, MISO looped to MOSI so the
//     received word equals the transmitted one.
// -----------------------------------------------------------------------------
module tb_spi_mstr_gen;

   localparam int W  = 16, NSS  = 4, HP  = 4, FR  = 2, BK  = 4;
   localparam int T0 = FR + 2*W*HP + BK;      // 134
   localparam int W1 = 8,  NSS1 = 5, HP1 = 2, FR1 = 3, BK1 = 2;
   localparam int T1 = FR1 + 2*W1*HP1 + BK1;  // 37

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, wrt, cpol, cpha, MISO;
   logic [W-1:0]  cmd, rd_data;
   logic [1:0]    ss_sel;
   logic          busy, done, SCLK, MOSI;
   logic [NSS-1:0] SS_n;

   logic          wrt1, cpol1, cpha1, MISO1;
   logic [W1-1:0] cmd1, rd1;
   logic [2:0]    sel1;
   logic          busy1, done1, SCLK1, MOSI1;
   logic [NSS1-1:0] SS1_n;

   assign MISO1 = MOSI1;

   spi_mstr_gen #(.WIDTH(W), .NUM_SS(NSS), .HALF_PER(HP), .FRONT(FR), .BACK(BK)) u0 (
      .clk(clk), .rst(rst), .wrt(wrt), .cmd(cmd), .ss_sel(ss_sel), .cpol(cpol),
      .cpha(cpha), .MISO(MISO), .busy(busy), .done(done), .rd_data(rd_data),
      .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI));

   spi_mstr_gen #(.WIDTH(W1), .NUM_SS(NSS1), .HALF_PER(HP1), .FRONT(FR1), .BACK(BK1)) u1 (
      .clk(clk), .rst(rst), .wrt(wrt1), .cmd(cmd1), .ss_sel(sel1), .cpol(cpol1),
      .cpha(cpha1), .MISO(MISO1), .busy(busy1), .done(done1), .rd_data(rd1),
      .SCLK(SCLK1), .SS_n(SS1_n), .MOSI(MOSI1));

   int n_chk = 0, n_pass = 0, cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ------------------------------------------------------ behavioural slave
   logic [W-1:0] slv_word, slv_sh, slv_rx, slv_prev;
   logic         slv_cpol, slv_cpha, slv_first, slv_lead, slv_on;
   int           slv_rise;

   assign slv_on = (SS_n === 4'hE) || (SS_n === 4'hD) || (SS_n === 4'hB) || (SS_n === 4'h7);

   initial begin MISO = 1'b0; slv_rx = '0; slv_prev = '0; slv_rise = 0; end

   always @(posedge slv_on) begin
      slv_sh = slv_word; slv_rx = '0; slv_rise = 0;
      slv_cpol = cpol; slv_cpha = cpha; slv_first = 1'b1;
      MISO = slv_word[W-1];
   end

   always @(negedge slv_on) slv_prev = slv_rx;

   always @(SCLK) if (slv_on) begin
      slv_lead = (SCLK !== slv_cpol);
      if (SCLK === 1'b1) slv_rise++;
      if (slv_lead ^ slv_cpha) slv_rx = {slv_rx[W-2:0], MOSI};
      else if (slv_cpha && slv_first) slv_first = 1'b0;
      else begin slv_sh = slv_sh << 1; MISO = slv_sh[W-1]; end
   end

   // ------------------------------------------------------- timing model (u0)
   // k = edges since acceptance; SCLK toggles after edges FR+j*HP, j=1..2W.
   function automatic logic sclk_at(int k, logic pol);
      if (k >= FR && k < FR + 2*W*HP) return pol ^ ((((k - FR) / HP) % 2) == 1);
      return pol;
   endfunction

   // Index (from MSB) of the bit on MOSI after edge k.
   function automatic int bit_at(int k, logic ph);
      int st, b;
      st = ph ? FR + HP : FR;
      b  = (k < st) ? 0 : (k - st) / (2*HP);
      if (b > W-1) b = W-1;
      return b;
   endfunction

   logic          m_act, m_cpol, m_cpha;
   int            m_k;
   logic [W-1:0]  m_cmd, m_resp;
   logic [1:0]    m_sel;
   logic          e_busy, e_done, e_sclk, e_mosi;
   logic [NSS-1:0] e_ss;
   logic [W-1:0]  e_rd;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_act = 1'b0; e_done = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_rd = '0;
      end else if (!m_act) begin
         e_done = 1'b0;
         e_sclk = cpol;
         if (wrt) begin
            m_act = 1'b1; m_k = 0; m_cmd = cmd; m_resp = slv_word;
            m_cpol = cpol; m_cpha = cpha; m_sel = ss_sel;
            e_mosi = cmd[W-1];
         end
      end else begin
         m_k++;
         e_sclk = sclk_at(m_k, m_cpol);
         e_mosi = m_cmd[W-1-bit_at(m_k, m_cpha)];
         if (m_k == T0) begin m_act = 1'b0; e_done = 1'b1; e_rd = m_resp; end
      end
      e_busy = m_act;
      e_ss   = '1;
      if (m_act) e_ss[m_sel] = 1'b0;
      #1;
      chk("busy",    32'(busy),    32'(e_busy));
      chk("done",    32'(done),    32'(e_done));
      chk("SS_n",    32'(SS_n),    32'(e_ss));
      chk("SCLK",    32'(SCLK),    32'(e_sclk));
      chk("MOSI",    32'(MOSI),    32'(e_mosi));
      chk("rd_data", 32'(rd_data), 32'(e_rd));
   end

   // ---------------------------------------------------------------- helpers
   task automatic wait_done(output int dn);
      dn = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin dn = cyc; break; end
      end
      if (dn < 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic xfer(input logic [W-1:0] c, input logic [1:0] s, input logic pl,
                       input logic ph, input logic [W-1:0] resp, output int lat,
                       output int low);
      int acc, dn;
      @(negedge clk); cmd = c; ss_sel = s; cpol = pl; cpha = ph; slv_word = resp;
      @(negedge clk); wrt = 1'b1;
      @(negedge clk); wrt = 1'b0; acc = cyc;
      low = 0; dn = -1;
      for (int i = 0; i < 400; i++) begin
         if (done) begin dn = cyc; break; end
         if (SS_n[s] == 1'b0) low++;
         @(negedge clk);
      end
      if (dn < 0) chk("xfer_timeout", 32'd0, 32'd1);
      lat = dn - acc;
   endtask

   task automatic xfer1(input logic [W1-1:0] c, input logic [2:0] s,
                        input logic [NSS1-1:0] sel_pat, output int lat, output int hits,
                        output int other);
      int acc, dn;
      @(negedge clk); cmd1 = c; sel1 = s;
      @(negedge clk); wrt1 = 1'b1;
      @(negedge clk); wrt1 = 1'b0; acc = cyc;
      hits = 0; other = 0; dn = -1;
      for (int i = 0; i < 200; i++) begin
         if (done1) begin dn = cyc; break; end
         if (SS1_n == sel_pat) hits++;
         else other++;
         @(negedge clk);
      end
      if (dn < 0) chk("xfer1_timeout", 32'd0, 32'd1);
      lat = dn - acc;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      int lat, low, d1, d2, acc, dn, cnt, hits, other;
      logic [W-1:0] exp_rd;
      rst = 1'b1; wrt = 1'b0; cmd = '0; ss_sel = '0; cpol = 1'b0; cpha = 1'b0;
      slv_word = '0; wrt1 = 1'b0; cmd1 = '0; sel1 = '0; cpol1 = 1'b1; cpha1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_SS_n", 32'(SS_n), 32'hF);
      chk("rst_SCLK", 32'(SCLK), 32'd0);
      chk("rst_rd",   32'(rd_data), 32'd0);
      chk("rst_SS1",  32'(SS1_n), 32'h1F);
      rst = 1'b0;

      // Mode 0 basic transfer to slave 2.
      xfer(16'hA5C3, 2'd2, 1'b0, 1'b0, 16'h3C5A, lat, low);
      chk("m0_latency", 32'(lat), 32'd134);
      chk("m0_ss2_low", 32'(low), 32'd134);
      chk("m0_slave_rx", 32'(slv_prev), 32'hA5C3);
      chk("m0_rd", 32'(rd_data), 32'h3C5A);
      chk("m0_rises", 32'(slv_rise), 32'd16);

      // All four modes, slave echoes what it last received.
      for (int m = 0; m < 4; m++) begin
         exp_rd = (m == 0) ? 16'hA5C3 : 16'h8001;
         xfer(16'h8001, 2'(m), m[1], m[0], slv_prev, lat, low);
         chk($sformatf("mode%0d_rd", m), 32'(rd_data), 32'(exp_rd));
         chk($sformatf("mode%0d_slave_rx", m), 32'(slv_prev), 32'h8001);
         chk($sformatf("mode%0d_latency", m), 32'(lat), 32'd134);
         repeat (3) @(negedge clk);
         chk($sformatf("mode%0d_idle_sclk", m), 32'(SCLK), 32'(m[1]));
      end

      // Back-to-back: wrt held across done.
      @(negedge clk); cmd = 16'h1234; ss_sel = 2'd1; cpol = 1'b0; cpha = 1'b0;
      slv_word = 16'hBEEF;
      @(negedge clk); wrt = 1'b1;
      @(negedge clk); cmd = 16'hFFFF; slv_word = 16'h0F0F;
      wait_done(d1);
      chk("b2b_gap_ss", 32'(SS_n), 32'hF);
      chk("b2b_rd1", 32'(rd_data), 32'hBEEF);
      @(negedge clk);
      chk("b2b_reselect", 32'(SS_n), 32'hD);
      chk("b2b_busy", 32'(busy), 32'd1);
      wrt = 1'b0;
      wait_done(d2);
      chk("b2b_spacing", 32'(d2 - d1), 32'd135);
      chk("b2b_rx1", 32'(slv_rx), 32'hFFFF);
      chk("b2b_rd2", 32'(rd_data), 32'h0F0F);

      // Mid-transfer wrt pulse and input changes are ignored.
      @(negedge clk); cmd = 16'h5A0F; ss_sel = 2'd3; cpol = 1'b1; cpha = 1'b0;
      slv_word = 16'h1357;
      @(negedge clk); wrt = 1'b1;
      @(negedge clk); wrt = 1'b0; acc = cyc;
      repeat (40) @(negedge clk);
      cmd = 16'hFFFF; cpol = 1'b0; cpha = 1'b1; ss_sel = 2'd0; wrt = 1'b1;
      @(negedge clk); wrt = 1'b0;
      repeat (20) @(negedge clk);
      cpol = 1'b1; cpha = 1'b0;
      wait_done(dn);
      chk("ign_latency", 32'(dn - acc), 32'd134);
      chk("ign_slave_rx", 32'(slv_prev), 32'h5A0F);
      chk("ign_rd", 32'(rd_data), 32'h1357);

      // Reset in the middle of bit 7.
      @(negedge clk); cmd = 16'h0FF0; ss_sel = 2'd0; cpol = 1'b1; cpha = 1'b1;
      slv_word = 16'hC0DE;
      @(negedge clk); wrt = 1'b1;
      @(negedge clk); wrt = 1'b0;
      repeat (60) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_SS_n", 32'(SS_n), 32'hF);
      chk("abort_SCLK", 32'(SCLK), 32'd0);
      chk("abort_MOSI", 32'(MOSI), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rd",   32'(rd_data), 32'd0);
      rst = 1'b0;
      cnt = 0;
      repeat (150) begin @(negedge clk); if (done) cnt++; end
      chk("abort_no_done", 32'(cnt), 32'd0);
      xfer(16'h0FF0, 2'd0, 1'b1, 1'b1, 16'hC0DE, lat, low);
      chk("after_abort_latency", 32'(lat), 32'd134);
      chk("after_abort_rd", 32'(rd_data), 32'hC0DE);
      chk("after_abort_rx", 32'(slv_prev), 32'h0FF0);

      // 8-bit instance: out-of-range select, then slave 4.
      xfer1(8'hC6, 3'd5, 5'h1F, lat, hits, other);
      chk("u1_nosel_latency", 32'(lat), 32'd37);
      chk("u1_nosel_ss_low", 32'(other), 32'd0);
      chk("u1_nosel_rd", 32'(rd1), 32'hC6);
      xfer1(8'h3B, 3'd4, 5'h0F, lat, hits, other);
      chk("u1_sel4_latency", 32'(lat), 32'd37);
      chk("u1_sel4_low", 32'(hits), 32'd37);
      chk("u1_sel4_rd", 32'(rd1), 32'h3B);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
